// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: branch kinds, PSW flag positions and FSM states shared by the resolve unit.
package branch_resolve_pkg;
  typedef enum logic [3:0] {
    CC_BL  = 4'd0,
    CC_BEQ = 4'd1,
    CC_BNE = 4'd2,
    CC_BC  = 4'd3,
    CC_BNC = 4'd4,
    CC_BN  = 4'd5,
    CC_BGE = 4'd6,
    CC_BLT = 4'd7,
    CC_BRA = 4'd8,
    CC_RET = 4'd9
  } cond_code_e;
  localparam int PSW_C = 0;
  localparam int PSW_Z = 1;
  localparam int PSW_N = 2;
  localparam int PSW_V = 4;
  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_e;
endpackage

// File: rtl/branch_resolve_link_stack.sv
// link_stack: circular return-address stack; a push on full overwrites the oldest entry.
module link_stack #(
  parameter int DATA_W   = 16,
  parameter int LR_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [DATA_W-1:0]           i_data,
  output logic [DATA_W-1:0]           o_top,
  output logic [$clog2(LR_DEPTH):0]   o_count,
  output logic                        o_overflow,
  output logic                        o_underflow
);
  localparam int PW = $clog2(LR_DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_W-1:0] r_mem [LR_DEPTH];
  logic [PW-1:0]     r_wp;
  logic [CW-1:0]     r_cnt;
  logic              w_full;
  logic              w_empty;
  assign w_full  = r_cnt == CW'(LR_DEPTH);
  assign w_empty = r_cnt == '0;
  assign o_top   = w_empty ? '0 : r_mem[r_wp - PW'(1)];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_data;
  // r_wp always names the next slot; when full that slot holds the oldest entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp        <= '0;
      r_cnt       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_push) begin
      r_wp       <= r_wp + PW'(1);
      r_cnt      <= w_full ? r_cnt : r_cnt + CW'(1);
      o_overflow <= o_overflow | w_full;
    end else if (i_pop) begin
      r_wp        <= w_empty ? r_wp : r_wp - PW'(1);
      r_cnt       <= w_empty ? r_cnt : r_cnt - CW'(1);
      o_underflow <= o_underflow | w_empty;
    end
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves conditional branches against the PSW, detects mispredicts,
// drives a fixed-length flush and maintains the BL/RET link stack.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int LR_DEPTH     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cond_valid_i,
  input  logic [3:0]                  cond_code_i,
  input  logic [DATA_W-1:0]           psw_i,
  input  logic                        predicted_taken_i,
  input  logic [DATA_W-1:0]           target_i,
  input  logic [DATA_W-1:0]           fallthru_i,
  output logic                        mispredict_o,
  output logic [DATA_W-1:0]           redirect_pc_o,
  output logic                        flush_o,
  output logic                        busy_o,
  output logic [DATA_W-1:0]           lr_o,
  output logic [$clog2(LR_DEPTH):0]   lr_count_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);
  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  state_e            r_state, w_state_nxt;
  logic [FW-1:0]     r_fcnt, w_fcnt_nxt;
  logic              w_acc, w_taken, w_ret_hit, w_mis, w_take_mis, w_unused;
  logic [DATA_W-1:0] w_red;
  logic              w_c, w_z, w_n, w_v;
  assign w_c = psw_i[PSW_C];
  assign w_z = psw_i[PSW_Z];
  assign w_n = psw_i[PSW_N];
  assign w_v = psw_i[PSW_V];
  assign w_unused = &{1'b0, psw_i};
  assign w_acc = cond_valid_i && r_state == S_IDLE;
  assign w_ret_hit = cond_code_i == CC_RET && lr_count_o != '0;
  assign w_taken = (cond_code_i == CC_BL || cond_code_i == CC_BRA) ? 1'b1 :
                   cond_code_i == CC_BEQ ? w_z :
                   cond_code_i == CC_BNE ? !w_z :
                   cond_code_i == CC_BC  ? w_c :
                   cond_code_i == CC_BNC ? !w_c :
                   cond_code_i == CC_BN  ? w_n :
                   cond_code_i == CC_BGE ? w_n == w_v :
                   cond_code_i == CC_BLT ? w_n != w_v : 1'b0;
  // an empty-stack RET falls through to the generic not-taken compare
  assign w_mis = cond_code_i > 4'd9 ? 1'b0 :
                 w_ret_hit ? (!predicted_taken_i || target_i != lr_o) :
                 w_taken != predicted_taken_i;
  assign w_red = w_ret_hit ? lr_o : w_taken ? target_i : fallthru_i;
  assign w_take_mis = w_acc && w_mis;
  link_stack #(.DATA_W(DATA_W), .LR_DEPTH(LR_DEPTH)) u_link_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_acc && cond_code_i == CC_BL),
    .i_pop       (w_acc && cond_code_i == CC_RET),
    .i_data      (fallthru_i),
    .o_top       (lr_o),
    .o_count     (lr_count_o),
    .o_overflow  (overflow_o),
    .o_underflow (underflow_o)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fcnt        <= '0;
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fcnt        <= w_fcnt_nxt;
      mispredict_o  <= w_take_mis;
      redirect_pc_o <= w_take_mis ? w_red : '0;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (r_state == S_IDLE) begin
      if (w_take_mis) begin
        w_state_nxt = S_FLUSH;
        w_fcnt_nxt  = FW'(FLUSH_CYCLES - 1);
      end
    end else if (r_fcnt == '0) w_state_nxt = S_IDLE;
    else w_fcnt_nxt = r_fcnt - FW'(1);
  end
  assign flush_o = r_state == S_FLUSH;
  assign busy_o  = flush_o;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed stimulus checked every cycle against a queue-based model,
// plus literal checks of the documented scenarios.
module tb_branch_resolve;
  localparam int D  = 4;
  localparam int FC = 2;
  logic        clk = 1'b0;
  logic        rst, cond_valid_i, predicted_taken_i;
  logic [3:0]  cond_code_i;
  logic [15:0] psw_i, target_i, fallthru_i;
  logic        mispredict_o, flush_o, busy_o, overflow_o, underflow_o;
  logic [15:0] redirect_pc_o, lr_o;
  logic [2:0]  lr_count_o;
  int          tests = 0, fails = 0;
  bit          chk_en = 0;
  logic [15:0] stk [$];
  bit          m_ovf, m_unf, m_mis;
  logic [15:0] m_red;
  int          m_flush;

  always #5 clk = ~clk;

  branch_resolve #(.DATA_W(16), .LR_DEPTH(D), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .cond_valid_i(cond_valid_i), .cond_code_i(cond_code_i),
    .psw_i(psw_i), .predicted_taken_i(predicted_taken_i), .target_i(target_i),
    .fallthru_i(fallthru_i), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .flush_o(flush_o), .busy_o(busy_o), .lr_o(lr_o), .lr_count_o(lr_count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_top();
    return stk.size() > 0 ? stk[$] : 16'h0;
  endfunction

  task automatic model_edge();
    bit idle, acc, tk, mis, c, z, n, v;
    logic [15:0] red;
    if (rst) begin
      stk.delete();
      m_ovf = 0; m_unf = 0; m_mis = 0; m_red = 0; m_flush = 0;
      return;
    end
    idle = m_flush == 0;
    acc  = cond_valid_i && idle;
    c = psw_i[0]; z = psw_i[1]; n = psw_i[2]; v = psw_i[4];
    mis = 0; red = 0; tk = 0;
    if (acc && cond_code_i <= 4'd8) begin
      case (cond_code_i)
        4'd0, 4'd8: tk = 1;
        4'd1: tk = z;
        4'd2: tk = !z;
        4'd3: tk = c;
        4'd4: tk = !c;
        4'd5: tk = n;
        4'd6: tk = n == v;
        4'd7: tk = n != v;
        default: tk = 0;
      endcase
      mis = tk != predicted_taken_i;
      red = tk ? target_i : fallthru_i;
      if (cond_code_i == 4'd0) begin
        stk.push_back(fallthru_i);
        if (stk.size() > D) begin
          void'(stk.pop_front());
          m_ovf = 1;
        end
      end
    end else if (acc && cond_code_i == 4'd9) begin
      if (stk.size() > 0) begin
        red = stk[$];
        mis = !predicted_taken_i || target_i != red;
        void'(stk.pop_back());
      end else begin
        m_unf = 1;
        mis = predicted_taken_i;
        red = fallthru_i;
      end
    end
    m_mis = mis;
    m_red = red;
    m_flush = idle ? (mis ? FC : 0) : m_flush - 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mispredict", mispredict_o, m_mis);
      if (m_mis) chk("redirect", redirect_pc_o, m_red);
      chk("flush", flush_o, m_flush > 0);
      chk("busy", busy_o, m_flush > 0);
      chk("lr", lr_o, m_top());
      chk("lr_count", lr_count_o, stk.size());
      chk("overflow", overflow_o, m_ovf);
      chk("underflow", underflow_o, m_unf);
    end
  end

  task automatic step(input bit v, input logic [3:0] c, input logic [15:0] psw, input bit p,
                      input logic [15:0] tg, input logic [15:0] ft, input bit r);
    rst = r; cond_valid_i = v; cond_code_i = c; psw_i = psw;
    predicted_taken_i = p; target_i = tg; fallthru_i = ft;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic req(input logic [3:0] c, input logic [15:0] psw, input bit p,
                     input logic [15:0] tg, input logic [15:0] ft);
    step(1, c, psw, p, tg, ft, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0);
  endtask

  logic [3:0]  t_code [10] = '{4'd6, 4'd7, 4'd3, 4'd4, 4'd5, 4'd8, 4'd12, 4'd15, 4'd1, 4'd2};
  logic [15:0] t_psw  [10] = '{16'h14, 16'h04, 16'h01, 16'h01, 16'h00, 16'h00, 16'h00, 16'h00, 16'h00, 16'h00};
  bit          t_pred [10] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 0};

  initial begin
    step(1, 4'd0, 16'h0, 1, 16'h0, 16'h0077, 1);
    step(0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 1);
    chk_en = 1;
    chk("rst_count", lr_count_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_lr", lr_o, 0);
    req(4'd1, 16'h0002, 1, 16'h0300, 16'h0102);
    chk("beq_mis", mispredict_o, 0);
    chk("beq_flush", flush_o, 0);
    req(4'd2, 16'h0002, 1, 16'h0300, 16'h0104);
    chk("bne_mis", mispredict_o, 1);
    chk("bne_red", redirect_pc_o, 16'h0104);
    chk("bne_flush1", flush_o, 1);
    req(4'd0, 16'h0, 1, 16'h0, 16'h0999);
    chk("drop_mis", mispredict_o, 0);
    chk("drop_flush2", flush_o, 1);
    chk("drop_count", lr_count_o, 0);
    idle(1);
    chk("flush_end", flush_o, 0);
    req(4'd0, 16'h0, 1, 16'h0400, 16'h0010);
    chk("bl_lr", lr_o, 16'h0010);
    chk("bl_count", lr_count_o, 1);
    req(4'd9, 16'h0, 1, 16'h0010, 16'h0020);
    chk("ret_mis", mispredict_o, 0);
    chk("ret_count", lr_count_o, 0);
    for (int i = 0; i < 5; i++) req(4'd0, 16'h0, 1, 16'h0500, 16'h000A + 16'(i));
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_count", lr_count_o, 4);
    for (int i = 0; i < 4; i++) begin
      chk("pop_top", lr_o, 16'h000E - 16'(i));
      req(4'd9, 16'h0, 1, 16'h000E - 16'(i), 16'h0600);
      chk("pop_mis", mispredict_o, 0);
    end
    chk("pop_empty", lr_count_o, 0);
    req(4'd9, 16'h0, 1, 16'h0055, 16'h0200);
    chk("unf_flag", underflow_o, 1);
    chk("unf_mis", mispredict_o, 1);
    chk("unf_red", redirect_pc_o, 16'h0200);
    idle(2);
    req(4'd0, 16'h0, 1, 16'h0, 16'h0030);
    req(4'd9, 16'h0, 1, 16'h0031, 16'h0040);
    chk("ret_tgt_mis", mispredict_o, 1);
    chk("ret_tgt_red", redirect_pc_o, 16'h0030);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      req(t_code[i], t_psw[i], t_pred[i], 16'h1000 + 16'(i), 16'h2000 + 16'(i));
      idle(2);
    end
    req(4'd6, 16'h0010, 1, 16'h0700, 16'h0702);
    chk("bge_mis", mispredict_o, 1);
    chk("bge_red", redirect_pc_o, 16'h0702);
    step(0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 1);
    chk("rst_mid_flush", flush_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_mis", mispredict_o, 0);
    chk("rst_mid_count", lr_count_o, 0);
    chk("rst_mid_ovf", overflow_o, 0);
    chk("rst_mid_unf", underflow_o, 0);
    req(4'd8, 16'h0, 1, 16'h0800, 16'h0802);
    req(4'd0, 16'h0, 1, 16'h0900, 16'h0902);
    chk("post_rst_count", lr_count_o, 1);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL take parameter DATA_W, default 16: PC/PSW width.
REQ-002 SHALL take parameter LR_DEPTH, default 4: link-stack entries; power of two, at least 2.
REQ-003 SHALL take parameter FLUSH_CYCLES, default 2: flush_o hold length; at least 1.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cond_valid_i  in  1  resolve request this cycle.
- cond_code_i  in  4  branch kind (REQ-008).
- psw_i  in  DATA_W  PSW; bit C=0, Z=1, N=2, V=4.
- predicted_taken_i  in  1  fetch-stage prediction.
- target_i  in  DATA_W  predicted target.
- fallthru_i  in  DATA_W  PC of next sequential instruction; BL link value.
- mispredict_o  out  1  one-cycle pulse.
- redirect_pc_o  out  DATA_W  corrected PC; valid while mispredict_o=1.
- flush_o  out  1  squash younger pipeline stages.
- busy_o  out  1  high in FLUSH; requests ignored.
- lr_o  out  DATA_W  top of link stack; 0 when empty.
- lr_count_o  out  $clog2(LR_DEPTH)+1  occupied entries.
- overflow_o  out  1  sticky; push on full.
- underflow_o  out  1  sticky; RET on empty.

Function
REQ-005 A request SHALL be accepted only when cond_valid_i=1 and the state is IDLE; requests in FLUSH SHALL be dropped with no state change.
REQ-006 actual_taken SHALL be evaluated combinationally from the psw_i value present in the accept cycle.
REQ-007 mispredict_o, redirect_pc_o and the link-stack update SHALL be registered: visible exactly 1 cycle after accept.
REQ-008 Codes and taken conditions:
- 0 BL: always taken; push.
- 1 BEQ: Z.
- 2 BNE: !Z.
- 3 BC: C.
- 4 BNC: !C.
- 5 BN: N.
- 6 BGE: N==V.
- 7 BLT: N!=V.
- 8 BRA: always taken.
- 9 RET: taken, pop.
- 10-15: no operation, never a mispredict.
REQ-009 Codes 0-8 SHALL mispredict when actual_taken != predicted_taken_i; redirect_pc_o = actual_taken ? target_i : fallthru_i.
REQ-010 RET with non-empty stack: actual target = lr_o; SHALL mispredict when predicted_taken_i=0 or target_i != lr_o; redirect_pc_o = lr_o; entry popped.
REQ-011 RET with empty stack: underflow_o set; stack unchanged; treated as not taken (mispredict iff predicted_taken_i=1, redirect fallthru_i).
REQ-012 BL SHALL push fallthru_i; on full, oldest entry is overwritten (circular wrap), count stays LR_DEPTH, overflow_o set.
REQ-013 Pointer arithmetic SHALL be modulo LR_DEPTH; count saturates at 0 and LR_DEPTH.
REQ-014 FSM states:
- IDLE -> FLUSH on an accepted mispredicting request.
- FLUSH -> IDLE after FLUSH_CYCLES cycles.
REQ-015 flush_o and busy_o SHALL be high during exactly the FLUSH_CYCLES cycles starting with the mispredict_o cycle.
REQ-016 mispredict_o SHALL be high for the first FLUSH cycle only.
REQ-017 Correct predictions SHALL cause no flush; back-to-back correct requests SHALL be accepted every cycle.

Reset
REQ-018 rst SHALL, on the next edge, return the FSM to IDLE, clear the FLUSH counter and empty the stack.
REQ-019 rst SHALL clear all outputs to 0, including mid-FLUSH, and clear overflow_o and underflow_o.
REQ-020 A request presented in the reset cycle SHALL be discarded.

Structure
REQ-021 A shared package SHALL hold the cond_code enum (values 0-9), the PSW bit-index constants C, Z, N and V, and the FSM state enum.
REQ-022 The link stack SHALL be one sub-module, link_stack: push/pop, top, count and overflow/underflow flags, parameterised by DATA_W and LR_DEPTH.

Verification
REQ-023 BEQ, psw_i=0x0002, predicted_taken_i=1 -> no mispredict, flush_o stays 0.
REQ-024 BNE, psw_i=0x0002, predicted_taken_i=1, fallthru_i=0x0104 -> next cycle mispredict_o=1, redirect_pc_o=0x0104; flush_o high 2 cycles; a request in cycle 2 is dropped.
REQ-025 BL with fallthru_i=0x0010, then RET with target_i=0x0010, predicted_taken_i=1 -> lr_o=0x0010, count 1; RET gives no mispredict, count 0.
REQ-026 5 BLs with fallthru_i 0x0A-0x0E at LR_DEPTH=4 -> overflow_o=1, count 4; then 4 RETs pop 0x0E, 0x0D, 0x0C, 0x0B.
REQ-027 RET on empty stack, predicted_taken_i=1, fallthru_i=0x0200 -> underflow_o=1, mispredict_o=1, redirect_pc_o=0x0200.
REQ-028 BGE mispredict, psw_i=0x0010, then rst during the first FLUSH cycle -> next cycle flush_o=0, busy_o=0, lr_count_o=0, sticky flags 0.
